// File: rtl/axil_arbiter_priority_wr.sv
// axil_arbiter_priority_wr: fixed-priority AXI-Lite write-channel arbiter.
// Shares one slave AW/W/B port among NUM_MASTERS requesters; the lowest index wins.
// A grant is held from arbitration until the B handshake, so one write is outstanding.
// Optional response watchdog: define AXIL_ARB_TIMEOUT_EN to add the TERR state and
// the sticky timeout_flag output.
module axil_arbiter_priority_wr #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] m_axil_awaddr,
  input  logic [NUM_MASTERS-1:0]                m_axil_awvalid,
  output logic [NUM_MASTERS-1:0]                m_axil_awready,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] m_axil_wdata,
  input  logic [NUM_MASTERS*AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  input  logic [NUM_MASTERS-1:0]                m_axil_wvalid,
  output logic [NUM_MASTERS-1:0]                m_axil_wready,
  output logic [NUM_MASTERS*2-1:0]              m_axil_bresp,
  output logic [NUM_MASTERS-1:0]                m_axil_bvalid,
  input  logic [NUM_MASTERS-1:0]                m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]             s_axil_awaddr,
  output logic                                  s_axil_awvalid,
  input  logic                                  s_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]             s_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]           s_axil_wstrb,
  output logic                                  s_axil_wvalid,
  input  logic                                  s_axil_wready,
  input  logic [1:0]                            s_axil_bresp,
  input  logic                                  s_axil_bvalid,
  output logic                                  s_axil_bready,
  output logic [NUM_MASTERS-1:0]                grant,
`ifdef AXIL_ARB_TIMEOUT_EN
  output logic                                  timeout_flag,
`endif
  output logic                                  busy
);

  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;

`ifdef AXIL_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StAddr, StResp, StTerr} state_e;
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TimerW-1:0] timer_q;
  logic              timeout_flag_q;
`else
  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;
`endif

  state_e                    state_q, state_d;
  logic [NUM_MASTERS-1:0]    grant_q, grant_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [NUM_MASTERS-1:0]    req, winner;
  logic                      g_awvalid, g_wvalid, g_bready;
  logic [AXI_ADDR_WIDTH-1:0] g_awaddr;
  logic [AXI_DATA_WIDTH-1:0] g_wdata;
  logic [StrbW-1:0]          g_wstrb;

  // Request vector, lowest-index winner and the granted master's payload.
  always_comb begin
    req       = m_axil_awvalid & m_axil_wvalid;
    // Isolate the lowest set bit.
    winner    = req & (~req + NUM_MASTERS'(1));
    g_awvalid = |(m_axil_awvalid & grant_q);
    g_wvalid  = |(m_axil_wvalid & grant_q);
    g_bready  = |(m_axil_bready & grant_q);
    g_awaddr  = '0;
    g_wdata   = '0;
    g_wstrb   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        g_awaddr = m_axil_awaddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        g_wdata  = m_axil_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        g_wstrb  = m_axil_wstrb[i*StrbW +: StrbW];
      end
    end
  end

  // Next-state logic and all channel outputs.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    m_axil_awready = '0;
    m_axil_wready  = '0;
    m_axil_bvalid  = '0;
    m_axil_bresp   = '0;
    s_axil_awaddr  = '0;
    s_axil_awvalid = 1'b0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = '0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d   = winner;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        s_axil_awaddr  = g_awaddr;
        s_axil_wdata   = g_wdata;
        s_axil_wstrb   = g_wstrb;
        s_axil_awvalid = g_awvalid & ~aw_done_q;
        s_axil_wvalid  = g_wvalid & ~w_done_q;
        m_axil_awready = grant_q & {NUM_MASTERS{s_axil_awready & ~aw_done_q}};
        m_axil_wready  = grant_q & {NUM_MASTERS{s_axil_wready & ~w_done_q}};
        aw_done_d      = aw_done_q | (s_axil_awvalid & s_axil_awready);
        w_done_d       = w_done_q | (s_axil_wvalid & s_axil_wready);
        if (aw_done_d && w_done_d) state_d = StResp;
      end
      StResp: begin
        s_axil_bready = g_bready;
        m_axil_bvalid = grant_q & {NUM_MASTERS{s_axil_bvalid}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (grant_q[i]) m_axil_bresp[2*i +: 2] = s_axil_bresp;
        end
        if (s_axil_bvalid && g_bready) begin
          grant_d = '0;
          state_d = StIdle;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        else if (!s_axil_bvalid && timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StTerr;
        end
`endif
      end
`ifdef AXIL_ARB_TIMEOUT_EN
      StTerr: begin
        // Synthesised SLVERR; the slave B channel is left alone.
        m_axil_bvalid = grant_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (grant_q[i]) m_axil_bresp[2*i +: 2] = 2'b10;
        end
        if (g_bready) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
`endif
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State, grant and handshake-done registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  // Response watchdog: held at zero outside RESP so every RESP entry starts from zero.
  always_ff @(posedge aclk) begin
    if (areset) begin
      timer_q        <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      if (state_q != StResp) begin
        timer_q <= '0;
      end else if (timer_q != TimerW'(TIMEOUT_CYCLES - 1)) begin
        timer_q <= timer_q + TimerW'(1);
      end
      if (state_q == StResp && state_d == StTerr) timeout_flag_q <= 1'b1;
    end
  end

  assign timeout_flag = timeout_flag_q;
`endif

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);

endmodule
